// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_e;

  // Magnitude of a two's complement value; 0x80000000 maps to itself as unsigned 2^31.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencing for the multiply/divide unit: FSM, iteration counter and completion pulse.
module multdiv_ctrl
  import multdiv_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic dz,
  output logic load_c,
  output logic step_c,
  output logic finish_c,
  output logic busy,
  output logic rdy
);

  state_e             state;
  logic   [CNT_W-1:0] cnt;

  assign load_c   = start && (state != CALC);
  assign step_c   = (state == CALC);
  assign finish_c = step_c && (cnt == CNT_W'(WIDTH - 1));

  // A start in DONE chains straight into the next operation without passing IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          cnt <= '0;
          if (start && dz) begin
            state <= DONE;
            busy  <= 1'b0;
            rdy   <= 1'b1;
          end else if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            rdy   <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            rdy   <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide: magnitude shift-add / restoring divide,
// sign applied once at completion.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start_mult,
  input  logic             i_start_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [31:0]      i_insn,
  output logic [WIDTH-1:0] o_result,
  output logic             o_exception,
  output logic             o_rdy,
  output logic             o_busy,
  output logic [31:0]      o_insn
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic          start_c;
  logic          dz_c;
  logic          load_c;
  logic          step_c;
  logic          finish_c;
  op_e           op_c;
  op_e           op_q;
  logic          neg;
  logic [WIDTH-1:0] addend;
  logic [W2-1:0] acc;
  logic [W2-1:0] acc_next_c;
  logic [W2-1:0] shifted_c;
  logic [W2-1:0] signed_c;
  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] diff_c;
  logic [WIDTH:0] hi_c;
  logic          exc_c;

  assign start_c = i_start_mult | i_start_div;
  assign op_c    = i_start_mult ? OP_MULT : OP_DIV;
  assign dz_c    = (op_c == OP_DIV) && (i_b == '0);

  multdiv_ctrl u_ctrl (
    .clock    (clock),
    .reset    (reset),
    .start    (start_c),
    .dz       (dz_c),
    .load_c   (load_c),
    .step_c   (step_c),
    .finish_c (finish_c),
    .busy     (o_busy),
    .rdy      (o_rdy)
  );

  // One iteration step; the final step feeds the result register directly.
  always_comb begin
    sum_c     = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
    shifted_c = acc << 1;
    diff_c    = {1'b0, shifted_c[W2-1:WIDTH]} - {1'b0, addend};
    if (op_q == OP_MULT) begin
      acc_next_c = {sum_c, acc[WIDTH-1:1]};
    end else if (!diff_c[WIDTH]) begin
      acc_next_c = {diff_c[WIDTH-1:0], shifted_c[WIDTH-1:1], 1'b1};
    end else begin
      acc_next_c = shifted_c;
    end
    signed_c = neg ? -acc_next_c : acc_next_c;
    hi_c     = signed_c[W2-1:WIDTH-1];
    exc_c    = (op_q == OP_MULT) && !((&hi_c) || !(|hi_c));
  end

  // Mult: acc starts as {0, |b|} and adds |a|. Div: acc starts as {0, |a|} against |b|.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= OP_MULT;
      neg         <= 1'b0;
      addend      <= '0;
      acc         <= '0;
      o_result    <= '0;
      o_exception <= 1'b0;
      o_insn      <= '0;
    end else if (load_c) begin
      op_q   <= op_c;
      neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      addend <= (op_c == OP_MULT) ? mag(i_a) : mag(i_b);
      acc    <= (op_c == OP_MULT) ? {WIDTH'(0), mag(i_b)} : {WIDTH'(0), mag(i_a)};
      o_insn <= i_insn;
      if (dz_c) begin
        o_result    <= '0;
        o_exception <= 1'b1;
      end
    end else if (step_c) begin
      acc <= acc_next_c;
      if (finish_c) begin
        o_result    <= signed_c[WIDTH-1:0];
        o_exception <= exc_c;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: expected results queued at issue, compared at o_rdy.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic        i_start_mult;
  logic        i_start_div;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] i_insn;
  logic [31:0] o_result;
  logic        o_exception;
  logic        o_rdy;
  logic        o_busy;
  logic [31:0] o_insn;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] insn;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  multdiv_unit dut (
    .clock       (clock),
    .reset       (reset),
    .i_start_mult(i_start_mult),
    .i_start_div (i_start_div),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_insn      (i_insn),
    .o_result    (o_result),
    .o_exception (o_exception),
    .o_rdy       (o_rdy),
    .o_busy      (o_busy),
    .o_insn      (o_insn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {exception, result} from plain 64-bit signed arithmetic.
  function automatic logic [32:0] model(input bit mul, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [32:0] top;
    int q;
    if (mul) begin
      p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      top = p[63:31];
      return {!((&top) || (top == 33'd0)), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  task automatic push(input logic [31:0] res, input logic exc, input logic [31:0] insn);
    exp_t e;
    e.res  = res;
    e.exc  = exc;
    e.insn = insn;
    sb.push_back(e);
  endtask

  // Drives a start for one edge; returns #1 after that edge (E0).
  task automatic start_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] insn);
    @(negedge clock);
    i_start_mult = mul;
    i_start_div  = !mul;
    i_a          = a;
    i_b          = b;
    i_insn       = insn;
    @(posedge clock);
    #1;
    i_start_mult = 1'b0;
    i_start_div  = 1'b0;
  endtask

  task automatic issue(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] insn);
    logic [32:0] m;
    m = model(mul, a, b);
    push(m[31:0], m[32], insn);
    start_op(mul, a, b, insn);
  endtask

  // Waits for o_rdy from the current sample point, counting edges and busy cycles.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input bit pulse);
    int   n = 0;
    int   busy_n = 0;
    int   both = 0;
    exp_t e;
    if (o_busy) busy_n++;
    while (!o_rdy && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (o_busy) busy_n++;
      if (o_busy && o_rdy) both++;
    end
    if (!o_rdy) begin
      check({tag, "_timeout"}, 64'(o_rdy), 64'd1);
      return;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({tag, "_busy_rdy_overlap"}, 64'(both), 64'd0);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_result"}, 64'(o_result), 64'(e.res));
    check({tag, "_exception"}, 64'(o_exception), 64'(e.exc));
    check({tag, "_insn"}, 64'(o_insn), 64'(e.insn));
    if (pulse) begin
      @(posedge clock);
      #1;
      check({tag, "_rdy_pulse"}, 64'(o_rdy), 64'd0);
    end
  endtask

  initial begin
    int rdy_cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    reset        = 1'b0;
    i_start_mult = 1'b0;
    i_start_div  = 1'b0;
    i_a          = '0;
    i_b          = '0;
    i_insn       = '0;
    #1 reset = 1'b1;
    #1;
    check("reset_outputs", {o_result, o_insn}, 64'd0);
    check("reset_flags", {61'd0, o_exception, o_rdy, o_busy}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Test-plan operations with hand-derived expectations.
    push(32'hFFFF_FFD6, 1'b0, 32'h0000_0101);
    start_op(1'b1, 32'd7, -32'sd6, 32'h0000_0101);
    wait_done("mult_7x-6", 32, 32, 1'b1);

    push(32'h0000_0000, 1'b1, 32'h0000_0102);
    start_op(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0102);
    wait_done("mult_ovf", 32, 32, 1'b1);

    push(32'h8000_0000, 1'b0, 32'h0000_0103);
    start_op(1'b1, 32'hFFFF_8000, 32'h0001_0000, 32'h0000_0103);
    wait_done("mult_min", 32, 32, 1'b1);

    push(32'hFFFF_FFFD, 1'b0, 32'h0000_0201);
    start_op(1'b0, -32'sd7, 32'd2, 32'h0000_0201);
    wait_done("div_-7/2", 32, 32, 1'b1);

    push(32'h8000_0000, 1'b0, 32'h0000_0202);
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0202);
    wait_done("div_min/-1", 32, 32, 1'b1);

    push(32'h0000_0000, 1'b1, 32'h0000_0203);
    start_op(1'b0, 32'd5, 32'd0, 32'h0000_0203);
    wait_done("div_by_zero", 0, 0, 1'b1);

    // Both starts at once: multiply wins.
    push(32'd12, 1'b0, 32'h0000_0301);
    @(negedge clock);
    i_start_mult = 1'b1;
    i_start_div  = 1'b1;
    i_a          = 32'd3;
    i_b          = 32'd4;
    i_insn       = 32'h0000_0301;
    @(posedge clock);
    #1;
    i_start_mult = 1'b0;
    i_start_div  = 1'b0;
    wait_done("both_starts", 32, 32, 1'b1);

    // A few random operands against the arithmetic model.
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k < 3) ? $urandom : 32'($urandom_range(1, 1000));
      if (k == 4) rb = -rb;
      issue(k < 3, ra, rb, 32'h0000_0400 + 32'(k));
      wait_done("random_op", 32, 32, 1'b1);
    end

    // Start during CALC is ignored; the div's result and tag come back.
    push(32'd14, 1'b0, 32'h0000_00D1);
    start_op(1'b0, 32'd100, 32'd7, 32'h0000_00D1);
    repeat (9) @(posedge clock);
    start_op(1'b1, 32'd9, 32'd9, 32'h0000_00EE);
    wait_done("ignored_start", 22, 22, 1'b0);
    check("ignored_start_idle", {62'd0, o_rdy, o_busy}, 64'd2);

    // Back-to-back: start sampled in the DONE cycle.
    issue(1'b1, 32'd1000, 32'd1000, 32'h0000_0501);
    wait_done("b2b_first", 32, 32, 1'b0);
    issue(1'b1, -32'sd5, 32'd5, 32'h0000_0502);
    wait_done("b2b_second", 32, 32, 1'b1);

    // Asynchronous reset at cycle 15 of CALC aborts the op.
    start_op(1'b1, 32'h1234, 32'd5, 32'h0000_0601);
    repeat (14) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_data", {o_result, o_insn}, 64'd0);
    check("midreset_flags", {61'd0, o_exception, o_rdy, o_busy}, 64'd0);
    @(negedge clock);
    reset   = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (o_rdy) rdy_cnt++;
    end
    check("midreset_no_rdy", 64'(rdy_cnt), 64'd0);

    issue(1'b0, 32'd1000, -32'sd3, 32'h0000_0701);
    wait_done("after_reset", 32, 32, 1'b1);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative 32-bit signed multiply/divide unit in the execute stage, directly upstream of the P/W latch. It accepts one operation at a time, computes it over 32 iteration cycles, and then pulses a ready flag for one cycle. While that flag is high it also presents the result, the exception flag and the originating instruction word, which are exactly what the P/W latch captures. The stall logic uses `o_busy` to freeze the front of the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  reset, asynchronous, active-high.
- `i_start_mult`  in  1  start a signed multiply of `i_a * i_b`.
- `i_start_div`  in  1  start a signed divide of `i_a / i_b`.
- `i_a`  in  WIDTH  operand A (multiplicand/dividend), two's complement.
- `i_b`  in  WIDTH  operand B (multiplier/divisor), two's complement.
- `i_insn`  in  32  instruction word of the issuing op, captured at start.
- `o_result`  out  WIDTH  low WIDTH bits of the product, or the quotient.
- `o_exception`  out  1  multiply overflow or divide-by-zero.
- `o_rdy`  out  1  one-cycle completion pulse; goes to the P/W latch `i_MD_rdy`.
- `o_busy`  out  1  high while an operation is in flight (CALC state).
- `o_insn`  out  32  captured `i_insn` of the current or last operation.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE:**
  - Start sampled at posedge: capture operand magnitudes (|a|, |b|), the result sign (sign(a) xor sign(b)), the op type and `i_insn`.
  - Counter cleared, then go to CALC.
  - Exception: divide with `i_b` == 0 goes straight to DONE with result 0 and exception 1.
- **CALC:**
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, using a 2·WIDTH-bit accumulator.
  - Counter runs 0..WIDTH-1; the state moves to DONE on the edge where the counter equals WIDTH-1.
- **DONE:**
  - On entry, register the sign-corrected result into `o_result` and `o_exception`.
  - `o_rdy` = 1 for exactly this cycle.
  - Next edge goes to IDLE, or directly to CALC if a start is sampled in DONE.
- **Arithmetic:**
  - Multiply: a 64-bit signed product is formed; `o_result` = product[31:0]. `o_exception` = 1 unless product[63:31] are all equal.
  - Divide: the quotient truncates toward zero; the remainder is discarded.
  - 0x80000000 / -1 gives 0x80000000 with no exception.
- **Both starts high at once:** multiply wins.
- **Start while in CALC:** ignored; the operation in flight is unaffected.
- `o_result`, `o_exception` and `o_insn` hold their values until the next completion or start respectively.

## Timing
- **Reset values:** state IDLE, counter 0, `o_result` 0, `o_exception` 0, `o_rdy` 0, `o_busy` 0, `o_insn` 0.
- **Reset mid-operation:** the operation is aborted immediately (asynchronously) and no `o_rdy` is ever produced for it.
- **Latency, normal:** start sampled at edge E0; `o_busy` high after E0 through E32; `o_rdy` high between E32 and E33. Total 33 edges.
- **Latency, divide-by-zero:** `o_rdy` high between E0 and E1. `o_busy` never rises.
- **Back-to-back:** with a start sampled in DONE, the next `o_rdy` follows 33 edges after that start. Issue interval is therefore 33 cycles.
- `o_busy` and `o_rdy` are never high in the same cycle.

## Structure
- Shared package `multdiv_pkg` holds:
  - the state enum (IDLE/CALC/DONE);
  - the op-type enum (MULT/DIV);
  - `WIDTH`, and `CNT_W` = clog2(WIDTH).
- One sub-module, `multdiv_ctrl`: FSM plus iteration counter, with outputs load/step/finish/busy/rdy.
- The datapath (accumulator, magnitude and sign logic) stays in `multdiv_unit`.

## Test plan
- mult 7 × -6 → after 33 edges, `o_rdy` pulses for one cycle with `o_result` 0xFFFFFFD6 (-42) and `o_exception` 0; `o_busy` is high for 32 cycles.
- mult 0x00010000 × 0x00010000 → `o_result` 0x00000000, `o_exception` 1. mult 0xFFFF8000 × 0x00010000 → `o_result` 0x80000000, `o_exception` 0.
- div -7 / 2 → `o_result` 0xFFFFFFFD (-3), `o_exception` 0. div 0x80000000 / -1 → `o_result` 0x80000000, `o_exception` 0.
- div 5 / 0 → `o_rdy` on the cycle after the start with `o_result` 0 and `o_exception` 1; `o_busy` stays 0.
- Start of a new mult at cycle 10 of an ongoing div → ignored; the div result and `i_insn` tag from the div are delivered. A start issued in the DONE cycle → a second `o_rdy` 33 edges later with the new `o_insn`.
- `reset` asserted mid-CALC at cycle 15 → all outputs go to 0 immediately and no `o_rdy` appears in the following 40 cycles. A subsequent start then completes normally.
